// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and parity helper for regfile_mp (parity used only when RF_PARITY_EN is defined)
package rf_pkg;

  typedef enum logic {RF_IDLE, RF_SCRUB} rf_state_t;

  // Widest data word the parity helper accepts; callers zero-extend into it.
  localparam int RF_PAR_MAX_W = 256;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [RF_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/scrub bus of regfile_mp; carries par_err when RF_PARITY_EN is defined
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                      we;
  logic [ADDR_W-1:0]         wa;
  logic [DATA_W-1:0]         wd;
  logic [NREAD*ADDR_W-1:0]   ra;
  logic [NREAD*DATA_W-1:0]   rd;
  logic                      clr_req;
  logic                      busy;
`ifdef RF_PARITY_EN
  logic [NREAD-1:0]          par_err;

  modport master (output we, wa, wd, ra, clr_req, input rd, busy, par_err);
  modport slave  (input we, wa, wd, ra, clr_req, output rd, busy, par_err);
`else
  modport master (output we, wa, wd, ra, clr_req, input rd, busy);
  modport slave  (input we, wa, wd, ra, clr_req, output rd, busy);
`endif
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port: bypass, zero-register mux, parity check (RF_PARITY_EN)
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ra,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] mem_data,
`ifdef RF_PARITY_EN
  input  logic              mem_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rd
);

  logic is_zero;
  logic is_bypass;

  // wr_en already excludes the zero register, so is_zero wins over bypass only in meaning, not in practice.
  assign is_zero   = (ZERO_REG != 0) && (ra == '0);
  assign is_bypass = wr_en && (wa == ra);

  // Output register: scrub and zero-register reads load 0, a same-cycle write forwards new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
    end else if (flush || is_zero) begin
      rd <= '0;
    end else if (is_bypass) begin
      rd <= wd;
    end else begin
      rd <= mem_data;
    end
  end

`ifdef RF_PARITY_EN
  logic [RF_PAR_MAX_W-1:0] chk_ext;
  logic                    par_bad;

  // Recompute parity of the stored data and compare with the stored bit.
  always_comb begin
    chk_ext                = '0;
    chk_ext[DATA_W-1:0]    = mem_data;
    par_bad                = (even_parity(chk_ext) != mem_par);
  end

  // Error flag travels with rd; forwarded and zero-register reads never come from storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= !flush && !is_zero && !is_bypass && par_bad;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with bypass, zero register and scrub FSM; RF_PARITY_EN adds parity
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RF_PARITY_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  logic [ENT_W-1:0]  mem [DEPTH];
  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] scrub_ptr, scrub_ptr_nxt;
  logic              scrubbing;
  logic              wr_acc;
  logic [ENT_W-1:0]  wd_ent;

  assign scrubbing = (state == RF_SCRUB);
  assign bus.busy  = scrubbing;
  assign wr_acc    = !scrubbing && bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

`ifdef RF_PARITY_EN
  logic [RF_PAR_MAX_W-1:0] wd_ext;

  // Stored word = {parity, data}; parity is fixed at write time.
  always_comb begin
    wd_ext             = '0;
    wd_ext[DATA_W-1:0] = bus.wd;
    wd_ent             = {even_parity(wd_ext), bus.wd};
  end
`else
  // Stored word is the data alone.
  always_comb begin
    wd_ent = bus.wd;
  end
`endif

  // FSM state and scrub pointer; reset always restarts a full scrub from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RF_SCRUB;
      scrub_ptr <= '0;
    end else begin
      state     <= state_nxt;
      scrub_ptr <= scrub_ptr_nxt;
    end
  end

  // Next state: clr_req starts a scrub from IDLE; scrub ends after clearing the last entry.
  always_comb begin
    state_nxt     = state;
    scrub_ptr_nxt = scrub_ptr;
    case (state)
      RF_IDLE: begin
        if (bus.clr_req) begin
          state_nxt     = RF_SCRUB;
          scrub_ptr_nxt = '0;
        end
      end
      RF_SCRUB: begin
        scrub_ptr_nxt = scrub_ptr + 1'b1;
        if (scrub_ptr == {ADDR_W{1'b1}}) begin
          state_nxt = RF_IDLE;
        end
      end
      default: begin
        state_nxt     = RF_SCRUB;
        scrub_ptr_nxt = '0;
      end
    endcase
  end

  // Storage: the scrub clears one entry per cycle, otherwise an accepted port write lands.
  always_ff @(posedge clk) begin
    if (scrubbing) begin
      mem[scrub_ptr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wa] <= wd_ent;
    end
  end

  logic [DATA_W-1:0] rd_q [NREAD];
`ifdef RF_PARITY_EN
  logic [NREAD-1:0]  par_q;
  assign bus.par_err = par_q;
`endif

  for (genvar g = 0; g < NREAD; g++) begin : g_rp
    logic [ADDR_W-1:0] ra_g;
    logic [ENT_W-1:0]  ent_g;

    assign ra_g  = bus.ra[g*ADDR_W +: ADDR_W];
    assign ent_g = mem[ra_g];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rp (
      .clk      (clk),
      .reset    (reset),
      .flush    (scrubbing),
      .ra       (ra_g),
      .wr_en    (wr_acc),
      .wa       (bus.wa),
      .wd       (bus.wd),
      .mem_data (ent_g[DATA_W-1:0]),
`ifdef RF_PARITY_EN
      .mem_par  (ent_g[DATA_W]),
      .par_err  (par_q[g]),
`endif
      .rd       (rd_q[g])
    );

    assign bus.rd[g*DATA_W +: DATA_W] = rd_q[g];
  end

endmodule
